// File: rtl/pio_pkg.sv
// Shared definitions for the multi-channel Avalon-MM PIO.
// Register offsets within a channel, register-field width and the bus word type.
package pio_pkg;

    localparam int REG_BITS = 3;

    localparam logic [REG_BITS-1:0] REG_DATA   = 3'd0;
    localparam logic [REG_BITS-1:0] REG_DIR    = 3'd1;
    localparam logic [REG_BITS-1:0] REG_MASK   = 3'd2;
    localparam logic [REG_BITS-1:0] REG_EDGE   = 3'd3;
    localparam logic [REG_BITS-1:0] REG_POL    = 3'd4;
    localparam logic [REG_BITS-1:0] REG_OUTSET = 3'd5;
    localparam logic [REG_BITS-1:0] REG_OUTCLR = 3'd6;

    typedef logic [31:0] pio_word_t;

endpackage

// File: rtl/pio_debounce.sv
// Per-bit input debouncer: dout follows din only after din has differed
// from dout for DEB_CYCLES consecutive cycles.
// Ports: clk, reset_n (async, active low), din (synchronised), dout (debounced).
module pio_debounce #(
    parameter int WIDTH      = 10,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt [WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (din[i] == dout[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    dout[i] <= din[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/avalon_multi_pio.sv
// Multi-channel Avalon-MM PIO: per-bit direction, atomic set/clear, edge capture + irq.
// Ports: clk, reset_n, avs_address {ch, reg}, avs_read, avs_write, avs_writedata,
//   avs_readdata (latency 1), pio_in, pio_out, pio_oe, irq.
// Build option: define PIO_DEBOUNCE_EN to insert pio_debounce on every input bit.
module avalon_multi_pio
    import pio_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = 10,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [3+$clog2(NUM_CH):0]    avs_address,
    input  logic                         avs_read,
    input  logic                         avs_write,
    input  logic [31:0]                  avs_writedata,
    output logic [31:0]                  avs_readdata,
    input  logic [NUM_CH*CH_WIDTH-1:0]   pio_in,
    output logic [NUM_CH*CH_WIDTH-1:0]   pio_out,
    output logic [NUM_CH*CH_WIDTH-1:0]   pio_oe,
    output logic                         irq
);

    localparam int W   = CH_WIDTH;
    localparam int NW  = NUM_CH * CH_WIDTH;
    // One extra channel bit so out-of-range channels are addressable (and read 0).
    localparam int CSW = $clog2(NUM_CH) + 1;

    logic [REG_BITS-1:0] reg_sel;
    logic [CSW-1:0]      ch_sel;
    logic [W-1:0]        wd;
    logic                unused_wdata;

    assign reg_sel      = avs_address[REG_BITS-1:0];
    assign ch_sel       = avs_address[REG_BITS +: CSW];
    assign wd           = avs_writedata[W-1:0];
    assign unused_wdata = ^{1'b0, avs_writedata};

    logic [NW-1:0] sync1, in_sync, in_db, prev_q;
    logic [NW-1:0] out_q, dir_q, mask_q, edge_q, pol_q;
    logic [NW-1:0] edge_det, edge_clr;
    pio_word_t     rdata;

`ifdef PIO_DEBOUNCE_EN
    for (genvar c = 0; c < NUM_CH; c++) begin : g_deb
        pio_debounce #(
            .WIDTH      (W),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_sync[c*W +: W]),
            .dout    (in_db[c*W +: W])
        );
    end
`else
    assign in_db = in_sync;
`endif

    // Polarity only selects which transition counts; prev_q always tracks in_db.
    assign edge_det = (~pol_q & in_db & ~prev_q) | (pol_q & ~in_db & prev_q);

    always_comb begin
        edge_clr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (avs_write && ch_sel == CSW'(c) && reg_sel == REG_EDGE)
                edge_clr[c*W +: W] = wd;
        end
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CSW'(c)) begin
                unique case (reg_sel)
                    REG_DATA: rdata[W-1:0] = (dir_q[c*W +: W] & out_q[c*W +: W]) |
                                             (~dir_q[c*W +: W] & in_db[c*W +: W]);
                    REG_DIR:  rdata[W-1:0] = dir_q[c*W +: W];
                    REG_MASK: rdata[W-1:0] = mask_q[c*W +: W];
                    REG_EDGE: rdata[W-1:0] = edge_q[c*W +: W];
                    REG_POL:  rdata[W-1:0] = pol_q[c*W +: W];
                    default:  rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= '0;
            in_sync      <= '0;
            prev_q       <= '0;
            out_q        <= '0;
            dir_q        <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            pol_q        <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            sync1   <= pio_in;
            in_sync <= sync1;
            prev_q  <= in_db;
            // A new edge wins over a same-cycle write-1-to-clear.
            edge_q  <= (edge_q & ~edge_clr) | edge_det;
            irq     <= |(edge_q & mask_q);
            if (avs_read)
                avs_readdata <= rdata;
            for (int c = 0; c < NUM_CH; c++) begin
                if (avs_write && ch_sel == CSW'(c)) begin
                    unique case (reg_sel)
                        REG_DATA:   out_q[c*W +: W]  <= wd;
                        REG_DIR:    dir_q[c*W +: W]  <= wd;
                        REG_MASK:   mask_q[c*W +: W] <= wd;
                        REG_POL:    pol_q[c*W +: W]  <= wd;
                        REG_OUTSET: out_q[c*W +: W]  <= out_q[c*W +: W] | wd;
                        REG_OUTCLR: out_q[c*W +: W]  <= out_q[c*W +: W] & ~wd;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign pio_out = out_q;
    assign pio_oe  = dir_q;

endmodule

// File: tb/tb_avalon_multi_pio.sv
// Scoreboard bench for avalon_multi_pio: reads queue expected data,
// a monitor pops and compares one cycle after each sampled read.
module tb_avalon_multi_pio;
    import pio_pkg::*;

    localparam int NUM_CH = 4;
    localparam int W      = 10;
    localparam int DEB    = 8;
    localparam int AW     = 4 + $clog2(NUM_CH);
`ifdef PIO_DEBOUNCE_EN
    localparam int LAT = DEB;
`else
    localparam int LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [AW-1:0]     avs_address = '0;
    logic              avs_read = 1'b0;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic [NUM_CH*W-1:0] pio_in = '0;
    logic [NUM_CH*W-1:0] pio_out;
    logic [NUM_CH*W-1:0] pio_oe;
    logic              irq;

    avalon_multi_pio #(
        .NUM_CH     (NUM_CH),
        .CH_WIDTH   (W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .pio_in        (pio_in),
        .pio_out       (pio_out),
        .pio_oe        (pio_oe),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    // Monitor: a read sampled at this edge presents data just after it.
    always @(posedge clk) begin
        if (reset_n && avs_read) begin
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: read data %h with nothing expected", avs_readdata);
            end else begin
                cur = sb.pop_front();
                if (avs_readdata !== cur.exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", cur.name, avs_readdata, cur.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // All bus tasks start at a negedge and return at the next negedge.
    task automatic bus(input bit r, input bit w, input int ch, input int rg,
                       input logic [31:0] d);
        avs_address   = AW'((ch << 3) | rg);
        avs_read      = r;
        avs_write     = w;
        avs_writedata = d;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        bus(1'b0, 1'b1, ch, rg, d);
    endtask

    task automatic rd(input int ch, input int rg, input logic [31:0] e, input string n);
        sb.push_back('{n, e});
        bus(1'b1, 1'b0, ch, rg, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", 64'(avs_readdata), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_oe", 64'(pio_oe), 64'h0);
        chk("rst_out", 64'(pio_out), 64'h0);
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 8; r++)
                rd(c, r, 32'h0, $sformatf("rst_c%0d_r%0d", c, r));

        // Direction, data, atomic set/clear on channel 1
        wr(1, REG_DIR, 32'h3FF);
        wr(1, REG_DATA, 32'h2A5);
        wr(1, REG_OUTSET, 32'h00F);
        chk("outset", 64'(pio_out[19:10]), 64'h2AF);
        wr(1, REG_OUTCLR, 32'h200);
        chk("outclr", 64'(pio_out[19:10]), 64'h0AF);
        chk("oe_ch1", 64'(pio_oe), 64'({10'h0, 10'h0, 10'h3FF, 10'h0}));
        rd(1, REG_DATA, 32'h0AF, "data_ch1");
        rd(1, REG_OUTSET, 32'h0, "outset_rd0");
        rd(1, REG_OUTCLR, 32'h0, "outclr_rd0");
        wr(1, REG_MASK, 32'hFFFF_FFFF);
        rd(1, REG_MASK, 32'h3FF, "mask_upper");

        // Rising edge on ch0 pin0: EDGE at k+3, irq at k+4
        wr(0, REG_MASK, 32'h1);
        wr(0, REG_POL, 32'h0);
        pio_in[0] = 1'b1;
        repeat (2 + LAT) @(negedge clk);
        rd(0, REG_EDGE, 32'h0, "edge_k2");
        chk("irq_k3", 64'(irq), 64'h0);
        rd(0, REG_EDGE, 32'h1, "edge_k3");
        chk("irq_k4", 64'(irq), 64'h1);
        rd(0, REG_DATA, 32'h1, "data_in_ch0");
        wr(0, REG_EDGE, 32'h1);
        chk("irq_hold", 64'(irq), 64'h1);
        @(negedge clk);
        chk("irq_clr", 64'(irq), 64'h0);
        rd(0, REG_EDGE, 32'h0, "edge_w1c_ch0");

        // Read and write in the same cycle returns the pre-write value
        sb.push_back('{"rw_same", 32'h1});
        bus(1'b1, 1'b1, 0, REG_MASK, 32'h3);
        rd(0, REG_MASK, 32'h3, "rw_after");

        // Falling-edge capture on ch2 bit2, set wins over clear
        wr(2, REG_POL, 32'h4);
        pio_in[22] = 1'b1;
        repeat (6 + LAT) @(negedge clk);
        rd(2, REG_EDGE, 32'h0, "pol_rise_ignored");
        pio_in[22] = 1'b0;
        repeat (2 + LAT) @(negedge clk);
        wr(2, REG_EDGE, 32'h4);
        rd(2, REG_EDGE, 32'h4, "set_wins");
        wr(2, REG_EDGE, 32'h4);
        rd(2, REG_EDGE, 32'h0, "edge_w1c_ch2");
        chk("irq_masked", 64'(irq), 64'h0);

        // Out-of-range addresses and channel isolation
        rd(NUM_CH, REG_DATA, 32'h0, "ch_oob");
        rd(7, REG_DIR, 32'h0, "ch7_oob");
        rd(0, 7, 32'h0, "reg7");
        wr(5, REG_DIR, 32'h3FF);
        wr(0, 7, 32'hFFFF_FFFF);
        wr(3, REG_DIR, 32'h3FF);
        wr(3, REG_DATA, 32'h155);
        chk("iso_out", 64'(pio_out), 64'({10'h155, 10'h0, 10'h0AF, 10'h0}));
        chk("iso_oe", 64'(pio_oe), 64'({10'h3FF, 10'h0, 10'h3FF, 10'h0}));
        rd(0, REG_DIR, 32'h0, "iso_dir0");
        rd(1, REG_DATA, 32'h0AF, "iso_data1");
        rd(2, REG_POL, 32'h4, "iso_pol2");
        wr(3, REG_DIR, 32'h0);

`ifdef PIO_DEBOUNCE_EN
        // Short glitch filtered, stable level accepted after DEB cycles
        pio_in[30] = 1'b1;
        repeat (5) @(negedge clk);
        pio_in[30] = 1'b0;
        repeat (20) @(negedge clk);
        rd(3, REG_EDGE, 32'h0, "glitch_edge");
        rd(3, REG_DATA, 32'h0, "glitch_data");
        pio_in[30] = 1'b1;
        repeat (9) @(negedge clk);
        rd(3, REG_DATA, 32'h0, "db_k9");
        rd(3, REG_DATA, 32'h1, "db_k10");
        repeat (3) @(negedge clk);
        rd(3, REG_EDGE, 32'h1, "db_edge");
`endif

        // Edges are captured on output-direction bits too
        pio_in[10] = 1'b1;
        repeat (6 + LAT) @(negedge clk);
        rd(1, REG_EDGE, 32'h1, "edge_on_output");
        chk("irq_ch1", 64'(irq), 64'h1);

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
